// File: rtl/user_proc_arb_pkg.sv
// Shared types and constants for the user-processing core arbiter.
package user_proc_arb_pkg;

    localparam int unsigned DEF_DATA_W = 512;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Ceiling log2, with a floor of 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        for (int i = 0; i < 32; i++) begin
            if (v != 0) begin
                r = r + 1;
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/user_proc_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             hit,
    output logic [ID_W-1:0]  idx
);

    int unsigned pos;

    always_comb begin
        hit = 1'b0;
        idx = '0;
        pos = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (32'(ptr) + k) % N_REQ;
            if (!hit && req[ID_W'(pos)]) begin
                hit = 1'b1;
                idx = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/user_proc_arbiter.sv
// Time-shares one user-processing core among N_REQ flows, one full
// parameter/packet/decision transaction per round-robin grant.
module user_proc_arbiter
    import user_proc_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ID_W   = clog2(N_REQ),
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [N_REQ*DATA_W-1:0] req_param_tdata,
    input  logic [N_REQ-1:0]        req_param_tvalid,
    output logic [N_REQ-1:0]        req_param_tready,
    input  logic [N_REQ*DATA_W-1:0] req_word_tdata,
    input  logic [N_REQ-1:0]        req_word_tvalid,
    input  logic [N_REQ-1:0]        req_word_tlast,
    output logic [N_REQ-1:0]        req_word_tready,
    output logic [N_REQ-1:0]        req_dec_tdata,
    output logic [N_REQ-1:0]        req_dec_tvalid,
    output logic [N_REQ-1:0]        req_dec_tlast,
    input  logic [N_REQ-1:0]        req_dec_tready,
    output logic [DATA_W-1:0]       core_param_tdata,
    output logic                    core_param_tvalid,
    output logic                    core_param_tlast,
    input  logic                    core_param_tready,
    output logic [DATA_W-1:0]       core_word_tdata,
    output logic                    core_word_tvalid,
    output logic                    core_word_tlast,
    input  logic                    core_word_tready,
    input  logic                    core_dec_tdata,
    input  logic                    core_dec_tvalid,
    input  logic                    core_dec_tlast,
    output logic                    core_dec_tready,
    output logic                    grant_valid,
    output logic [ID_W-1:0]         grant_id,
    output logic [CNT_W-1:0]        beat_count
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic              word_done;
    logic              pick_hit;
    logic [ID_W-1:0]   pick_idx;
    logic              word_hs;
    logic              dec_hs;
    logic [DATA_W-1:0] param_arr [N_REQ];
    logic [DATA_W-1:0] word_arr  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_split
        assign param_arr[i] = req_param_tdata[i*DATA_W +: DATA_W];
        assign word_arr[i]  = req_word_tdata[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req (req_param_tvalid),
        .ptr (rr_ptr),
        .hit (pick_hit),
        .idx (pick_idx)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the grant-steered stream mux; everything is quiet outside ACTIVE.
    always_comb begin
        state_nxt         = state;
        core_param_tdata  = '0;
        core_param_tvalid = 1'b0;
        core_param_tlast  = 1'b0;
        core_word_tdata   = '0;
        core_word_tvalid  = 1'b0;
        core_word_tlast   = 1'b0;
        core_dec_tready   = 1'b0;
        req_param_tready  = '0;
        req_word_tready   = '0;
        req_dec_tdata     = '0;
        req_dec_tvalid    = '0;
        req_dec_tlast     = '0;
        case (state)
            IDLE: begin
                if (pick_hit) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                core_param_tdata           = param_arr[grant_id];
                core_param_tvalid          = req_param_tvalid[grant_id];
                core_param_tlast           = 1'b1;
                req_param_tready[grant_id] = core_param_tready;
                core_word_tdata            = word_arr[grant_id];
                core_word_tvalid           = req_word_tvalid[grant_id] & ~word_done;
                core_word_tlast            = req_word_tlast[grant_id];
                req_word_tready[grant_id]  = core_word_tready & ~word_done;
                req_dec_tvalid[grant_id]   = core_dec_tvalid;
                req_dec_tdata[grant_id]    = core_dec_tdata;
                req_dec_tlast[grant_id]    = core_dec_tlast;
                core_dec_tready            = req_dec_tready[grant_id];
                if (core_dec_tvalid && req_dec_tready[grant_id]) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign word_hs     = core_word_tvalid & core_word_tready;
    assign dec_hs      = core_dec_tvalid & core_dec_tready;
    assign grant_valid = (state == ACTIVE);

    // Grant bookkeeping; grant_id and beat_count persist until the next grant.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr     <= '0;
            grant_id   <= '0;
            word_done  <= 1'b0;
            beat_count <= '0;
        end else begin
            if (state == IDLE && pick_hit) begin
                grant_id   <= pick_idx;
                word_done  <= 1'b0;
                beat_count <= '0;
            end
            if (word_hs) begin
                if (beat_count != '1) begin
                    beat_count <= beat_count + CNT_W'(1);
                end
                if (core_word_tlast) begin
                    word_done <= 1'b1;
                end
            end
            if (dec_hs) begin
                rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_user_proc_arbiter.sv
// Randomized scoreboard bench for user_proc_arbiter with an in-bench core and requester models.
module tb_user_proc_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned IW  = 2;
    localparam int unsigned CW  = 4;
    localparam int unsigned SAT = (1 << CW) - 1;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N*DW-1:0] req_param_tdata;
    logic [N-1:0]    req_param_tvalid;
    logic [N-1:0]    req_param_tready;
    logic [N*DW-1:0] req_word_tdata;
    logic [N-1:0]    req_word_tvalid;
    logic [N-1:0]    req_word_tlast;
    logic [N-1:0]    req_word_tready;
    logic [N-1:0]    req_dec_tdata;
    logic [N-1:0]    req_dec_tvalid;
    logic [N-1:0]    req_dec_tlast;
    logic [N-1:0]    req_dec_tready;
    logic [DW-1:0]   core_param_tdata;
    logic            core_param_tvalid;
    logic            core_param_tlast;
    logic            core_param_tready;
    logic [DW-1:0]   core_word_tdata;
    logic            core_word_tvalid;
    logic            core_word_tlast;
    logic            core_word_tready;
    logic            core_dec_tdata;
    logic            core_dec_tvalid;
    logic            core_dec_tlast;
    logic            core_dec_tready;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;
    logic [CW-1:0]   beat_count;

    user_proc_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW),
        .ID_W   (IW),
        .CNT_W  (CW)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .req_param_tdata   (req_param_tdata),
        .req_param_tvalid  (req_param_tvalid),
        .req_param_tready  (req_param_tready),
        .req_word_tdata    (req_word_tdata),
        .req_word_tvalid   (req_word_tvalid),
        .req_word_tlast    (req_word_tlast),
        .req_word_tready   (req_word_tready),
        .req_dec_tdata     (req_dec_tdata),
        .req_dec_tvalid    (req_dec_tvalid),
        .req_dec_tlast     (req_dec_tlast),
        .req_dec_tready    (req_dec_tready),
        .core_param_tdata  (core_param_tdata),
        .core_param_tvalid (core_param_tvalid),
        .core_param_tlast  (core_param_tlast),
        .core_param_tready (core_param_tready),
        .core_word_tdata   (core_word_tdata),
        .core_word_tvalid  (core_word_tvalid),
        .core_word_tlast   (core_word_tlast),
        .core_word_tready  (core_word_tready),
        .core_dec_tdata    (core_dec_tdata),
        .core_dec_tvalid   (core_dec_tvalid),
        .core_dec_tlast    (core_dec_tlast),
        .core_dec_tready   (core_dec_tready),
        .grant_valid       (grant_valid),
        .grant_id          (grant_id),
        .beat_count        (beat_count)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    // Source queues drained by the requester drivers; scoreboard queues drained by the monitor.
    logic [DW:0]   drv_w [N][$];
    logic [DW-1:0] drv_p [N][$];
    logic [DW:0]   exp_w [N][$];
    logic [DW-1:0] exp_p [N][$];
    logic          exp_dec [$];

    // Handshakes seen at the negedge, i.e. those that complete at the coming posedge.
    logic [N-1:0] f_param, f_word;
    logic         f_core_wlast, f_dec;

    logic         gv_prev, in_txn, m_done, expect_fall, core_tlast_seen;
    logic [N-1:0] req_prev, others;
    int           low_cnt, m_g, m_ptr, m_words, exp_g, core_delay, wr_mode;
    logic [DW:0]  w;
    logic         d;
    logic [DW-1:0] p;

    assign core_param_tready = core_dec_tvalid & core_dec_tready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_expect(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic add_pkt(input int r, input int len);
        logic [DW-1:0] pd;
        logic [DW-1:0] wd;
        pd = $urandom;
        drv_p[r].push_back(pd);
        exp_p[r].push_back(pd);
        for (int k = 0; k < len; k++) begin
            wd = $urandom;
            drv_w[r].push_back({(k == len - 1), wd});
            exp_w[r].push_back({(k == len - 1), wd});
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (drv_p[i].size() != 0 || drv_w[i].size() != 0) return 1'b0;
            if (exp_p[i].size() != 0 || exp_w[i].size() != 0) return 1'b0;
        end
        return exp_dec.size() == 0;
    endfunction

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            drv_p[i].delete();
            drv_w[i].delete();
            exp_p[i].delete();
            exp_w[i].delete();
        end
        exp_dec.delete();
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (n < max_cyc && !(all_empty() && !grant_valid && !in_txn)) begin
            @(negedge aclk);
            #1;
            n++;
        end
        chk("drain_timeout", 64'(n < max_cyc), 64'(1));
        repeat (3) @(negedge aclk);
    endtask

    // Monitor / scoreboard
    always @(negedge aclk) begin
        if (!aresetn) begin
            gv_prev = 1'b0; in_txn = 1'b0; m_done = 1'b0; expect_fall = 1'b0;
            low_cnt = 2; m_ptr = 0; m_words = 0; m_g = 0;
            f_param = '0; f_word = '0; f_core_wlast = 1'b0; f_dec = 1'b0;
            req_prev = '0;
        end else begin
            f_param      = req_param_tvalid & req_param_tready;
            f_word       = req_word_tvalid & req_word_tready;
            f_core_wlast = core_word_tvalid & core_word_tready & core_word_tlast;
            f_dec        = core_dec_tvalid & core_dec_tready;
            if (expect_fall) begin
                chk("release", 64'(grant_valid), 64'(0));
                chk("beat_count", 64'(beat_count), 64'((m_words > int'(SAT)) ? int'(SAT) : m_words));
                expect_fall = 1'b0;
                in_txn = 1'b0;
                low_cnt = 0;
            end else if (!in_txn && low_cnt >= 2 && req_prev != '0) begin
                chk("grant_latency", 64'(grant_valid), 64'(1));
            end
            if (grant_valid && !in_txn) begin
                chk("grant_gap", 64'(low_cnt >= 2), 64'(1));
                exp_g = rr_expect(req_prev, m_ptr);
                chk("grant_id", 64'(grant_id), 64'(exp_g));
                chk("beat_clear", 64'(beat_count), 64'(0));
                m_g = (exp_g < 0) ? 0 : exp_g;
                in_txn = 1'b1;
                m_words = 0;
                m_done = 1'b0;
            end
            if (in_txn && !expect_fall) begin
                others = ~(N'(1) << m_g);
                chk("grant_hold", 64'(grant_id), 64'(m_g));
                chk("others_quiet", 64'({req_param_tready & others, req_word_tready & others,
                                         req_dec_tvalid & others}), 64'(0));
                chk("param_valid", 64'(core_param_tvalid), 64'(req_param_tvalid[m_g]));
                chk("word_valid", 64'(core_word_tvalid), 64'(req_word_tvalid[m_g] & !m_done));
                chk("dec_ready", 64'(core_dec_tready), 64'(req_dec_tready[m_g]));
                if (core_word_tvalid && core_word_tready) begin
                    w = (exp_w[m_g].size() != 0) ? exp_w[m_g].pop_front() : 'x;
                    chk("word_data", 64'({core_word_tlast, core_word_tdata}), 64'(w));
                    m_words++;
                    if (w[DW] === 1'b1) m_done = 1'b1;
                end
                if (f_dec) begin
                    d = (exp_dec.size() != 0) ? exp_dec.pop_front() : 1'bx;
                    chk("dec_route", 64'({req_dec_tvalid[m_g], req_dec_tdata[m_g], req_dec_tlast[m_g]}),
                        64'({1'b1, d, 1'b1}));
                    p = (exp_p[m_g].size() != 0) ? exp_p[m_g].pop_front() : 'x;
                    chk("param_data", 64'({core_param_tvalid, core_param_tlast, core_param_tdata}),
                        64'({1'b1, 1'b1, p}));
                    expect_fall = 1'b1;
                    m_ptr = (m_g + 1) % N;
                end
            end
            if (!grant_valid) low_cnt++;
            gv_prev = grant_valid;
            req_prev = req_param_tvalid;
        end
    end

    // Requester drivers
    always @(posedge aclk) begin
        #1;
        if (!aresetn) begin
            req_param_tdata = '0; req_param_tvalid = '0;
            req_word_tdata = '0; req_word_tvalid = '0; req_word_tlast = '0;
            req_dec_tready = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (f_param[i] && drv_p[i].size() != 0) void'(drv_p[i].pop_front());
                if (f_word[i] && drv_w[i].size() != 0) void'(drv_w[i].pop_front());
                req_param_tvalid[i] = (drv_p[i].size() != 0);
                req_param_tdata[i*DW +: DW] = (drv_p[i].size() != 0) ? drv_p[i][0] : '0;
                req_word_tvalid[i] = (drv_w[i].size() != 0) && ($urandom_range(0, 4) != 0);
                req_word_tdata[i*DW +: DW] = (drv_w[i].size() != 0) ? drv_w[i][0][DW-1:0] : '0;
                req_word_tlast[i] = (drv_w[i].size() != 0) ? drv_w[i][0][DW] : 1'b0;
                req_dec_tready[i] = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Core model: takes the packet, then returns one decision (sometimes with the last word)
    always @(posedge aclk) begin
        #2;
        if (!aresetn) begin
            core_word_tready = 1'b0; core_dec_tvalid = 1'b0;
            core_dec_tdata = 1'b0; core_dec_tlast = 1'b0;
            core_tlast_seen = 1'b0; core_delay = 0;
        end else begin
            if (f_core_wlast && !core_dec_tvalid) begin
                core_tlast_seen = 1'b1;
                core_delay = $urandom_range(0, 3);
            end
            if (f_dec) begin
                core_dec_tvalid = 1'b0; core_dec_tdata = 1'b0; core_dec_tlast = 1'b0;
                core_tlast_seen = 1'b0;
            end
            core_word_tready = (wr_mode == 1) ? ~core_word_tready : ($urandom_range(0, 2) != 0);
            if (!core_dec_tvalid) begin
                if (core_tlast_seen) begin
                    if (core_delay == 0) begin
                        core_dec_tdata = 1'($urandom); core_dec_tvalid = 1'b1; core_dec_tlast = 1'b1;
                        exp_dec.push_back(core_dec_tdata);
                    end else begin
                        core_delay--;
                    end
                end else if (core_word_tvalid && core_word_tlast && $urandom_range(0, 3) == 0) begin
                    core_word_tready = 1'b1;
                    core_dec_tdata = 1'($urandom); core_dec_tvalid = 1'b1; core_dec_tlast = 1'b1;
                    exp_dec.push_back(core_dec_tdata);
                end
            end
        end
    end

    initial begin
        int n;
        wr_mode = 0;
        core_word_tready = 1'b0; core_dec_tvalid = 1'b0; core_dec_tdata = 1'b0; core_dec_tlast = 1'b0;
        req_param_tdata = '0; req_param_tvalid = '0; req_word_tdata = '0;
        req_word_tvalid = '0; req_word_tlast = '0; req_dec_tready = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_grant", 64'({grant_valid, grant_id, beat_count}), 64'(0));
        chk("reset_quiet", 64'({core_param_tvalid, core_word_tvalid, core_dec_tready,
                                req_param_tready, req_word_tready, req_dec_tvalid}), 64'(0));

        // All four requesting out of reset: expect 0,1,2,3,0,1,2,3
        for (int r = 0; r < N; r++) begin
            add_pkt(r, $urandom_range(1, 4));
            add_pkt(r, $urandom_range(1, 4));
        end
        @(posedge aclk); #3;
        aresetn = 1'b1;
        wait_drain(3000);

        // Lone requester 2 with a 3-word packet
        add_pkt(2, 3);
        wait_drain(1000);

        // Toggling core word ready over 5-word packets
        wr_mode = 1;
        add_pkt(1, 5);
        add_pkt(3, 5);
        add_pkt(0, 5);
        wait_drain(2000);
        wr_mode = 0;

        // Random traffic, including packets long enough to saturate beat_count
        for (int t = 0; t < 30; t++) begin
            add_pkt($urandom_range(0, N - 1), $urandom_range(1, 20));
            repeat ($urandom_range(0, 15)) @(negedge aclk);
        end
        wait_drain(20000);

        // Reset in the middle of a packet
        for (int r = 0; r < N; r++) add_pkt(r, 8);
        n = 0;
        while (!(grant_valid && beat_count >= 2) && n < 2000) begin
            @(negedge aclk); #1; n++;
        end
        chk("reset_setup", 64'(n < 2000), 64'(1));
        @(posedge aclk); #3;
        aresetn = 1'b0;
        #1;
        chk("midreset_grant", 64'({grant_valid, grant_id, beat_count}), 64'(0));
        chk("midreset_quiet", 64'({core_param_tvalid, core_word_tvalid, core_dec_tready,
                                   req_param_tready, req_word_tready, req_dec_tvalid}), 64'(0));
        clear_queues();
        repeat (2) @(posedge aclk);
        for (int r = 0; r < N; r++) add_pkt(r, $urandom_range(1, 4));
        @(posedge aclk); #3;
        aresetn = 1'b1;
        wait_drain(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
